// File: rtl/servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// servo_pwm_gen
// Period-based servo PWM generator. It takes a pulse width in clock cycles from
// the angle stepper and produces one high pulse per PWM period. The width is
// latched only on period boundaries, so a pulse is never glitched or cut short
// while the generator is running.
//
// Parameters
//   PERIOD     PWM period in clock cycles
//   MIN_WIDTH  lower clamp applied to the requested width
//   MAX_WIDTH  upper clamp applied to the requested width
//   Legal range: 1 <= MIN_WIDTH <= MAX_WIDTH < PERIOD <= 2**21
//
// Ports
//   CLK            system clock, rising edge
//   RST_N          synchronous active-low reset
//   enable         run request; low returns to idle and forces all outputs low
//   pulse_width    requested high time in clock cycles (sampled at load points)
//   pwm_out        servo signal (registered)
//   done_period    one-cycle strobe at every period wrap (registered)
//   width_clamped  high for the whole period whose loaded width was clamped
// -----------------------------------------------------------------------------
module servo_pwm_gen #(
    parameter int unsigned PERIOD    = 2_000_000,
    parameter int unsigned MIN_WIDTH = 50_000,
    parameter int unsigned MAX_WIDTH = 250_000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        enable,
    input  logic [20:0] pulse_width,
    output logic        pwm_out,
    output logic        done_period,
    output logic        width_clamped
);

    localparam int unsigned CNT_W = 21;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] WMIN     = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] WMAX     = CNT_W'(MAX_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_width;

    // Width that would be loaded if this edge were a load point.
    logic [CNT_W-1:0] clamped_width_c;
    logic             clamp_hit_c;

    // Full-width unsigned clamp of the requested pulse width.
    always_comb begin
        clamped_width_c = pulse_width;
        clamp_hit_c     = 1'b0;
        if (pulse_width < WMIN) begin
            clamped_width_c = WMIN;
            clamp_hit_c     = 1'b1;
        end else if (pulse_width > WMAX) begin
            clamped_width_c = WMAX;
            clamp_hit_c     = 1'b1;
        end
    end

    // Control FSM, period counter, shadow width and registered outputs.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state         <= IDLE;
            cnt           <= '0;
            active_width  <= WMIN;
            pwm_out       <= 1'b0;
            done_period   <= 1'b0;
            width_clamped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt         <= '0;
                    pwm_out     <= 1'b0;
                    done_period <= 1'b0;
                    if (enable) begin
                        // First load point: the first period uses this width.
                        active_width  <= clamped_width_c;
                        width_clamped <= clamp_hit_c;
                        state         <= RUN;
                    end else begin
                        width_clamped <= 1'b0;
                    end
                end

                RUN: begin
                    if (!enable) begin
                        // Emergency stop: truncate any pulse and drop everything.
                        state         <= IDLE;
                        cnt           <= '0;
                        pwm_out       <= 1'b0;
                        done_period   <= 1'b0;
                        width_clamped <= 1'b0;
                    end else begin
                        // Compare uses the pre-edge count, giving one cycle latency.
                        pwm_out <= (cnt < active_width);
                        if (cnt == CNT_LAST) begin
                            // Period wrap is the only place the shadow width changes.
                            cnt           <= '0;
                            done_period   <= 1'b1;
                            active_width  <= clamped_width_c;
                            width_clamped <= clamp_hit_c;
                        end else begin
                            cnt         <= cnt + CNT_W'(1);
                            done_period <= 1'b0;
                        end
                    end
                end

                default: begin
                    state         <= IDLE;
                    cnt           <= '0;
                    pwm_out       <= 1'b0;
                    done_period   <= 1'b0;
                    width_clamped <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_gen
// Self-checking bench for servo_pwm_gen with PERIOD=20, MIN_WIDTH=2,
// MAX_WIDTH=10. A behavioural model tracks how many edges have elapsed since
// the generator entered RUN and the list of widths loaded per period, and
// derives the expected outputs arithmetically from those.
// -----------------------------------------------------------------------------
module tb_servo_pwm_gen;

    localparam int P    = 20;
    localparam int WMIN = 2;
    localparam int WMAX = 10;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [20:0] pulse_width;
    logic        pwm_out;
    logic        done_period;
    logic        width_clamped;

    int n_cmp = 0;
    int n_bad = 0;

    servo_pwm_gen #(
        .PERIOD   (P),
        .MIN_WIDTH(WMIN),
        .MAX_WIDTH(WMAX)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .enable       (enable),
        .pulse_width  (pulse_width),
        .pwm_out      (pwm_out),
        .done_period  (done_period),
        .width_clamped(width_clamped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    bit running;
    int k;           // edges since the edge that entered RUN
    int wq[$];       // width loaded for period j
    bit cq[$];       // whether that load was clamped
    bit m_pwm, m_done, m_wc;

    function automatic int mclamp(input int x);
        if (x < WMIN) return WMIN;
        if (x > WMAX) return WMAX;
        return x;
    endfunction

    always @(posedge clk) begin
        int pwi;
        int c;
        pwi = int'(pulse_width);
        if (!rst_n) begin
            running = 0; m_pwm = 0; m_done = 0; m_wc = 0;
            wq.delete(); cq.delete();
        end else if (!running) begin
            m_pwm = 0; m_done = 0; m_wc = 0;
            if (enable) begin
                running = 1;
                k = 0;
                wq.delete(); cq.delete();
                wq.push_back(mclamp(pwi));
                cq.push_back(mclamp(pwi) != pwi);
                m_wc = cq[0];
            end
        end else if (!enable) begin
            running = 0; m_pwm = 0; m_done = 0; m_wc = 0;
        end else begin
            k++;
            c      = (k - 1) % P;
            m_pwm  = (c < wq[(k - 1) / P]);
            m_done = (c == P - 1);
            if (k % P == 0) begin
                wq.push_back(mclamp(pwi));
                cq.push_back(mclamp(pwi) != pwi);
            end
            m_wc = cq[k / P];
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Return to IDLE, then start a run with width w; leaves us just after E0.
    task automatic start_run(input logic [20:0] w);
        enable = 1'b0;
        tick();
        tick();
        pulse_width = w;
        enable      = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int first_rise;
        rst_n = 1'b0; enable = 1'b1; pulse_width = 21'd5;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({pwm_out, done_period, width_clamped} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_outputs cycle %0d: got %b%b%b, want 000", i, pwm_out, done_period, width_clamped);
            end
        end
        rst_n = 1'b1;
        first_rise = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_cmp++;
            if (pwm_out !== m_pwm) begin
                n_bad++;
                $display("FAIL reset_release_pwm tick %0d: got %b, want %b", i, pwm_out, m_pwm);
            end
            if (pwm_out === 1'b1 && first_rise < 0) first_rise = i;
        end
        n_cmp++;
        if (first_rise !== 2) begin
            n_bad++;
            $display("FAIL reset_first_rise: got edge %0d, want edge 2", first_rise);
        end
    endtask

    task automatic test_steady();
        int highs[3];
        int dones;
        start_run(21'd5);
        highs = '{0, 0, 0};
        dones = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            n_cmp++;
            if ({pwm_out, done_period, width_clamped} !== {m_pwm, m_done, m_wc}) begin
                n_bad++;
                $display("FAIL steady_cycle tick %0d: got %b%b%b, want %b%b%b", i,
                         pwm_out, done_period, width_clamped, m_pwm, m_done, m_wc);
            end
            if (pwm_out === 1'b1) highs[(i - 1) / P]++;
            if (done_period === 1'b1) begin
                dones++;
                n_cmp++;
                if (i % P != 0) begin
                    n_bad++;
                    $display("FAIL steady_done_position: got tick %0d, want multiple of %0d", i, P);
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (highs[j] != 5) begin
                n_bad++;
                $display("FAIL steady_width period %0d: got %0d, want 5", j, highs[j]);
            end
        end
        n_cmp++;
        if (dones != 3) begin
            n_bad++;
            $display("FAIL steady_done_count: got %0d, want 3", dones);
        end
    endtask

    task automatic test_clamp();
        logic [20:0] req[3];
        int          want_w[3];
        bit          want_c[3];
        int          highs;
        req    = '{21'd0, 21'h1FFFFF, 21'd10};
        want_w = '{2, 10, 10};
        want_c = '{1'b1, 1'b1, 1'b0};
        for (int t = 0; t < 3; t++) begin
            start_run(req[t]);
            highs = 0;
            for (int i = 1; i <= P; i++) begin
                tick();
                if (pwm_out === 1'b1) highs++;
                n_cmp++;
                if (width_clamped !== want_c[t]) begin
                    n_bad++;
                    $display("FAIL clamp_flag req %0h tick %0d: got %b, want %b", req[t], i, width_clamped, want_c[t]);
                end
            end
            n_cmp++;
            if (highs != want_w[t]) begin
                n_bad++;
                $display("FAIL clamp_width req %0h: got %0d, want %0d", req[t], highs, want_w[t]);
            end
        end
    endtask

    task automatic test_shadow();
        int highs[2];
        start_run(21'd4);
        highs = '{0, 0};
        for (int i = 1; i <= 2 * P; i++) begin
            tick();
            if (i == 2) pulse_width = 21'd9;   // counter now at 2, mid-pulse
            if (pwm_out === 1'b1) highs[(i - 1) / P]++;
            n_cmp++;
            if (pwm_out !== m_pwm) begin
                n_bad++;
                $display("FAIL shadow_cycle tick %0d: got %b, want %b", i, pwm_out, m_pwm);
            end
        end
        n_cmp++;
        if (highs[0] != 4 || highs[1] != 9) begin
            n_bad++;
            $display("FAIL shadow_widths: got %0d/%0d, want 4/9", highs[0], highs[1]);
        end
    endtask

    task automatic test_stepper_loop();
        int highs[12];
        int want;
        start_run(21'd2);
        for (int j = 0; j < 12; j++) highs[j] = 0;
        for (int i = 1; i <= 12 * P; i++) begin
            tick();
            if (pwm_out === 1'b1) highs[(i - 1) / P]++;
            if (done_period === 1'b1) pulse_width = pulse_width + 21'd1;
        end
        // Period 0 and 1 both use 2: the first increment lands at the first wrap.
        for (int j = 0; j < 12; j++) begin
            want = (j == 0) ? 2 : ((j + 1 > WMAX) ? WMAX : j + 1);
            n_cmp++;
            if (highs[j] != want) begin
                n_bad++;
                $display("FAIL stepper_width period %0d: got %0d, want %0d", j, highs[j], want);
            end
        end
    endtask

    task automatic test_abort_resume();
        int highs;
        int dones;
        start_run(21'd6);
        tick(); tick(); tick();          // counter now at 3, pulse high
        enable = 1'b0;
        tick();
        n_cmp++;
        if (pwm_out !== 1'b0 || done_period !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_edge: got pwm %b done %b, want 0 0", pwm_out, done_period);
        end
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done_period === 1'b1) dones++;
        end
        n_cmp++;
        if (dones != 0) begin
            n_bad++;
            $display("FAIL abort_no_done: got %0d strobes, want 0", dones);
        end
        enable = 1'b1;
        tick();
        highs = 0;
        for (int i = 1; i <= P; i++) begin
            tick();
            if (pwm_out === 1'b1) highs++;
        end
        n_cmp++;
        if (highs != 6) begin
            n_bad++;
            $display("FAIL resume_width: got %0d, want 6", highs);
        end
        // Drop enable so it is sampled low exactly on the next wrap edge.
        for (int i = 1; i <= P - 1; i++) tick();
        enable = 1'b0;
        tick();
        n_cmp++;
        if (done_period !== 1'b0 || pwm_out !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_abort: got done %b pwm %b, want 0 0", done_period, pwm_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)
                pulse_width = ($urandom_range(0, 9) == 0) ? 21'($urandom) : 21'($urandom_range(0, 14));
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            rst_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            tick();
            n_cmp++;
            if ({pwm_out, done_period, width_clamped} !== {m_pwm, m_done, m_wc}) begin
                n_bad++;
                $display("FAIL random_cycle %0d: got %b%b%b, want %b%b%b", i,
                         pwm_out, done_period, width_clamped, m_pwm, m_done, m_wc);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b0;
        pulse_width = '0;
        test_reset();
        test_steady();
        test_clamp();
        test_shadow();
        test_stepper_loop();
        test_abort_resume();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
